// File: rtl/sync_ctr5_pkg.sv
// ============================================================================
// Module      : sync_ctr5_pkg
// Description : Shared state encoding and default width for sync counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_ctr5_pkg;

  localparam int unsigned C_DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } ctr_state_e;

endpackage

`default_nettype wire

// File: rtl/inc_dec5.sv
// ============================================================================
// Module      : inc_dec5
// Description : Combinational inc/dec with inclusive limit and wrap detect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inc_dec5 #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic [WIDTH-1:0] i_max,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap
);

  // Up-count wraps on >= so a limit lowered below the count still rolls over.
  always_comb begin
    o_next = i_value;
    o_wrap = 1'b0;
    if (i_up) begin
      if (i_value >= i_max) begin
        o_next = '0;
        o_wrap = 1'b1;
      end else begin
        o_next = i_value + WIDTH'(1);
      end
    end else begin
      if (i_value == '0) begin
        o_next = i_max;
        o_wrap = 1'b1;
      end else begin
        o_next = i_value - WIDTH'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sync_ctr5.sv
// ============================================================================
// Module      : sync_ctr5
// Description : Up/down modulo counter with start/stop FSM and one-shot mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ctr5
  import sync_ctr5_pkg::*;
#(
  parameter int unsigned WIDTH   = C_DEFAULT_WIDTH,
  parameter bit          ONESHOT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] Din,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] Dout,
  output logic             tc,
  output logic             wrap,
  output logic             busy
);

  ctr_state_e       state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] w_next;
  logic             w_wrap;

  inc_dec5 #(
    .WIDTH (WIDTH)
  ) u_inc_dec5 (
    .i_value (dout_q),
    .i_max   (max),
    .i_up    (up),
    .o_next  (w_next),
    .o_wrap  (w_wrap)
  );

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    wrap_d  = 1'b0;

    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (en) begin
          dout_d = w_next;
          wrap_d = w_wrap;
          if (w_wrap && ONESHOT) state_d = DONE;
        end
      end
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase

    // Load beats counting and all transitions except DONE->IDLE.
    if (load) begin
      dout_d  = (Din > max) ? max : Din;
      wrap_d  = 1'b0;
      state_d = (state_q == DONE) ? IDLE : state_q;
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dout_q  <= '0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
    end
  end

  assign Dout = dout_q;
  assign wrap = wrap_q;
  assign busy = busy_q;
  assign tc   = (state_q == RUN) && (up ? (dout_q == max) : (dout_q == '0));

endmodule

`default_nettype wire
